// File: rtl/core_defines.sv
// Shared fetch-side definitions: cache controller states, instruction width
// and the bubble instruction the F stage inserts.
package core_defines;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MDATA = 2'd2,
    S_RESP  = 2'd3
  } cache_state_e;

endpackage

// File: rtl/icache_tagarray.sv
// Valid bits and tags of the direct-mapped instruction cache. Provides the
// hit compare for a lookup index/tag, single-line install and bulk invalidate.
module icache_tagarray #(
  parameter int LINES = 16,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_all
);

  logic [LINES-1:0] valid_bits;
  logic [TAG_W-1:0] tag_mem [LINES];

  // One valid flag per line; the only state here that must come out of reset.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      logic v_reg;

      // Clear on reset or invalidate-all, set when this line is installed.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          v_reg <= 1'b0;
        end else if (inv_all) begin
          v_reg <= 1'b0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          v_reg <= 1'b1;
        end
      end

      assign valid_bits[gi] = v_reg;
    end
  endgenerate

  // Tags are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  assign hit = valid_bits[lk_idx] && (tag_mem[lk_idx] == lk_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache for the fetch stage. Hits answer one cycle
// after the request; misses refill a whole line from backing memory, one
// word per beat in ascending order, then answer in the RESP state.
module icache_dm
  import core_defines::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic [INSTR_W-1:0] resp_instr,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  cache_state_e state_reg, state_next;
  logic [ADDR_W-3:0]  addr_reg;        // latched word address of the request
  logic [OFF_W-1:0]   cnt_reg;         // refill beat counter
  logic               flush_pend_reg;
  logic               rdy_en_reg;      // holds req_ready low until the first clock after reset
  logic               resp_valid_reg;
  logic [INSTR_W-1:0] resp_instr_reg;

  logic [INSTR_W-1:0] data_mem [LINES*WORDS];

  // Field split of the incoming request and of the latched request.
  logic [ADDR_W-3:0] req_waddr;
  logic [OFF_W-1:0]  req_off, lat_off;
  logic [IDX_W-1:0]  req_idx, lat_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag;
  logic              unused_byte_bits;

  assign req_waddr        = req_addr[ADDR_W-1:2];
  assign unused_byte_bits = ^req_addr[1:0];
  assign req_off = req_waddr[OFF_W-1:0];
  assign req_idx = req_waddr[OFF_W +: IDX_W];
  assign req_tag = req_waddr[ADDR_W-3 -: TAG_W];
  assign lat_off = addr_reg[OFF_W-1:0];
  assign lat_idx = addr_reg[OFF_W +: IDX_W];
  assign lat_tag = addr_reg[ADDR_W-3 -: TAG_W];

  logic hit, accept, beat, last_beat, inv_all;

  assign req_ready = rdy_en_reg && (state_reg == S_IDLE) && !flush && !flush_pend_reg;
  assign accept    = req_valid && req_ready;
  assign beat      = (state_reg == S_MDATA) && mem_resp_valid;
  assign last_beat = beat && (cnt_reg == OFF_W'(WORDS - 1));
  // A pending flush is applied in the first IDLE cycle after the refill,
  // which also wipes the line that refill just installed.
  assign inv_all   = (state_reg == S_IDLE) && (flush || flush_pend_reg);

  icache_tagarray #(
    .LINES(LINES),
    .TAG_W(TAG_W),
    .IDX_W(IDX_W)
  ) u_tags (
    .clock  (clock),
    .reset  (reset),
    .lk_idx (req_idx),
    .lk_tag (req_tag),
    .hit    (hit),
    .wr_en  (last_beat),
    .wr_idx (lat_idx),
    .wr_tag (lat_tag),
    .inv_all(inv_all)
  );

  assign mem_req_valid = (state_reg == S_MREQ);
  assign mem_req_addr  = {addr_reg[ADDR_W-3:OFF_W], {(OFF_W + 2){1'b0}}};
  assign resp_valid    = resp_valid_reg;
  assign resp_instr    = resp_instr_reg;

  // Next-state logic of the refill controller.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (accept && !hit) state_next = S_MREQ;
      S_MREQ:  if (mem_req_ready)  state_next = S_MDATA;
      S_MDATA: if (last_beat)      state_next = S_RESP;
      S_RESP:                      state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // Control state, request latch, beat counter, flush bookkeeping and the
  // registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      rdy_en_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_instr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rdy_en_reg     <= 1'b1;
      resp_valid_reg <= 1'b0;
      if (accept) begin
        addr_reg <= req_waddr;
      end
      if (accept && hit) begin
        resp_valid_reg <= 1'b1;
        resp_instr_reg <= data_mem[{req_idx, req_off}];
      end
      if (beat) begin
        cnt_reg <= cnt_reg + 1'b1;   // wraps to 0 after the last beat
      end
      // The response is captured at the last-beat edge so it shows during
      // RESP; the requested word may be arriving on this very beat.
      if (last_beat) begin
        resp_valid_reg <= 1'b1;
        resp_instr_reg <= (lat_off == cnt_reg) ? mem_resp_data
                                               : data_mem[{lat_idx, lat_off}];
      end
      if (state_reg == S_IDLE) begin
        flush_pend_reg <= 1'b0;
      end else if (flush) begin
        flush_pend_reg <= 1'b1;
      end
    end
  end

  // Line data: written one word per refill beat, never reset.
  always_ff @(posedge clock) begin
    if (beat) begin
      data_mem[{lat_idx, cnt_reg}] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (LINES=16, WORDS=4). A cache-level model
// (valid/tag per line, backing memory contents, expected-response queue)
// is checked against the DUT on every negative clock edge; the directed
// sequence additionally pins hand-computed values.
module tb_icache_dm;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        flush;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_dm #(.ADDR_W(32), .LINES(LINES), .WORDS(WORDS)) dut (
    .clock         (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_instr    (resp_instr),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Backing instruction memory contents.
  function automatic logic [31:0] bmem(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    case (w)
      32'h0:   return 32'h0000_0000;
      32'h4:   return 32'h0800_0213;
      32'h8:   return 32'h0000_00B3;
      32'hC:   return 32'h0400_0113;
      default: return 32'hA500_0000 ^ w;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 16) % LINES);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (16 * LINES);
  endfunction

  // ---------------- cache-level model and per-cycle compare ----------------
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];
  logic [31:0] expq [$];
  bit          mbusy, mpend, ready_ok, resp_due;
  int          phase;        // 0 none, 1 awaiting memory handshake, 2 beats, 3 awaiting response
  int          beats;
  logic [31:0] maddr;

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    bit busy_start, exp_ready;
    logic [31:0] e;
    if (!reset) begin
      chk("reset_outputs", {27'd0, req_ready, resp_valid, mem_req_valid, |resp_instr, |mem_req_addr}, 32'd0);
      model_clear();
      expq.delete();
      mbusy = 0; mpend = 0; ready_ok = 0; resp_due = 0; phase = 0; beats = 0;
    end else begin
      busy_start = mbusy;
      exp_ready  = ready_ok && !mbusy && !flush && !mpend;
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, resp_due});
      if (resp_valid && expq.size() > 0) begin
        e = expq.pop_front();
        chk("resp_instr", resp_instr, e);
      end
      if (resp_valid && phase == 3) begin
        mbusy = 0;
        phase = 0;
      end
      resp_due = 0;
      // a flush seen during a refill takes effect once the cache is idle again
      if (mpend && !busy_start) begin
        model_clear();
        mpend = 0;
      end
      if (flush) begin
        if (busy_start) mpend = 1;
        else model_clear();
      end
      chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, phase == 1});
      if (phase == 1) begin
        chk("mem_req_addr", mem_req_addr, maddr & 32'hFFFF_FFF0);
        if (mem_req_ready) begin
          phase = 2;
          beats = 0;
        end
      end else if (phase == 2 && mem_resp_valid) begin
        beats++;
        if (beats == WORDS) begin
          mvalid[m_idx(maddr)] = 1'b1;
          mtag[m_idx(maddr)]   = m_tag(maddr);
          expq.push_back(bmem(maddr));
          resp_due = 1;
          phase = 3;
        end
      end
      if (req_valid && exp_ready) begin
        if (mvalid[m_idx(req_addr)] && mtag[m_idx(req_addr)] == m_tag(req_addr)) begin
          expq.push_back(bmem(req_addr));
          resp_due = 1;
        end else begin
          mbusy = 1;
          phase = 1;
          maddr = req_addr;
        end
      end
      ready_ok = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  // One fetch; plays the memory side on a miss. rdy_delay >= 1 cycles of
  // mem_req_ready low, gap idle cycles between beats, optional flush on a
  // beat, optional reset assertion on a beat (returns immediately then).
  task automatic do_fetch(input logic [31:0] a, input int rdy_delay, input int gap,
                          input int flush_beat, input int stop_beat,
                          output bit miss, output logic [31:0] instr,
                          output logic [31:0] line, output int lat);
    int n;
    miss = 0; instr = 32'hxxxx_xxxx; line = 32'hxxxx_xxxx; lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (resp_valid) begin
      instr = resp_instr;
      lat = 0;
      return;
    end
    if (!mem_req_valid) begin
      chk("hit_or_miss_seen", 32'd0, 32'd1);
      return;
    end
    miss = 1;
    line = mem_req_addr;
    repeat (rdy_delay) begin @(posedge clk); #1; end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      if (w > 0) repeat (gap) begin @(posedge clk); #1; end
      mem_resp_valid = 1'b1;
      mem_resp_data  = bmem(line + 32'(4 * w));
      if (w == flush_beat) flush = 1'b1;
      if (w == stop_beat) begin
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      flush = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 10);
    if (resp_valid) begin
      instr = resp_instr;
      lat = n;
    end
  endtask

  initial begin
    bit          miss;
    logic [31:0] instr, line;
    int          lat, cnt;

    reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("ready_before_first_clock", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_first_clock", {31'd0, req_ready}, 32'd1);

    // cold miss
    do_fetch(32'h4, 1, 0, -1, -1, miss, instr, line, lat);
    $display("cold miss 0x4: miss=%0d line=%h instr=%h lat=%0d", miss, line, instr, lat);
    chk("cold_miss", {31'd0, miss}, 32'd1);
    chk("cold_line", line, 32'h0000_0000);
    chk("cold_instr", instr, 32'h0800_0213);
    chk("cold_latency", 32'(lat), 32'd1);

    // hit in the freshly filled line
    do_fetch(32'hC, 1, 0, -1, -1, miss, instr, line, lat);
    $display("hit 0xC: miss=%0d instr=%h", miss, instr);
    chk("hit_miss_flag", {31'd0, miss}, 32'd0);
    chk("hit_instr", instr, 32'h0400_0113);

    // four back-to-back hits over the same line
    cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(4 * i);
      @(negedge clk);
      if (resp_valid) cnt++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (resp_valid) cnt++;
    $display("back-to-back hits 0x0-0xC: responses=%0d", cnt);
    chk("b2b_responses", 32'(cnt), 32'd4);

    // conflict miss on index 0
    do_fetch(32'h104, 1, 0, -1, -1, miss, instr, line, lat);
    $display("conflict 0x104: miss=%0d line=%h instr=%h", miss, line, instr);
    chk("conflict_miss", {31'd0, miss}, 32'd1);
    chk("conflict_line", line, 32'h0000_0100);
    do_fetch(32'h4, 1, 0, -1, -1, miss, instr, line, lat);
    $display("refetch 0x4 after conflict: miss=%0d instr=%h", miss, instr);
    chk("evicted_miss", {31'd0, miss}, 32'd1);
    chk("evicted_instr", instr, 32'h0800_0213);

    // memory backpressure and gapped beats
    do_fetch(32'h28, 3, 2, -1, -1, miss, instr, line, lat);
    $display("backpressure 0x28: miss=%0d line=%h instr=%h", miss, line, instr);
    chk("bp_line", line, 32'h0000_0020);
    chk("bp_instr", instr, 32'hA500_0028);

    // flush in IDLE blocks a concurrent request, then the line misses;
    // a flush during that refill still delivers its response
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk);
    chk("flush_blocks_req", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    do_fetch(32'h4, 1, 0, 1, -1, miss, instr, line, lat);
    $display("after idle flush 0x4 (flush mid-refill): miss=%0d instr=%h", miss, instr);
    chk("flush_idle_miss", {31'd0, miss}, 32'd1);
    chk("flush_pending_instr", instr, 32'h0800_0213);
    do_fetch(32'h4, 1, 0, -1, -1, miss, instr, line, lat);
    $display("after pending flush 0x4: miss=%0d instr=%h", miss, instr);
    chk("flush_pending_miss", {31'd0, miss}, 32'd1);

    // reset in the middle of a refill, stray beats afterwards
    do_fetch(32'h30, 1, 0, -1, 2, miss, instr, line, lat);
    #1;
    $display("reset during beat 2 of 0x30: ready=%b rv=%b mrv=%b instr=%h maddr=%h",
             req_ready, resp_valid, mem_req_valid, resp_instr, mem_req_addr);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_resp_instr", resp_instr, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    mem_resp_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    mem_resp_valid = 1'b0;
    do_fetch(32'h4, 1, 0, -1, -1, miss, instr, line, lat);
    $display("after reset 0x4: miss=%0d instr=%h", miss, instr);
    chk("post_reset_miss", {31'd0, miss}, 32'd1);
    chk("post_reset_instr", instr, 32'h0800_0213);

    repeat (3) @(posedge clk);
    chk("responses_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache. It replaces the flat instruction ROM in the fetch stage.
- Serves the F stage over a valid/ready request with a registered response.
- Refills whole lines from a backing instruction memory over a request/beat-response interface.
- Supports a full-cache flush (fence.i).
- Tag and data arrays are register-based; no SRAM macros.

Parameters:
ADDR_W, 32, byte-address width.
LINES, 16, number of lines; power of 2, ≥2.
WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
req_valid  in  1  fetch request valid.
req_ready  out  1  cache can accept a request this cycle.
req_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
resp_valid  out  1  one-cycle pulse; resp_instr is valid.
resp_instr  out  32  instruction word.
flush  in  1  invalidate all lines.
mem_req_valid  out  1  line refill request.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  ADDR_W  line-aligned byte address.
mem_resp_valid  in  1  one refill beat valid.
mem_resp_data  in  32  refill word; beats arrive in ascending word order.

Behaviour:
- Address split:
  - off = addr[OFF+1:2], with OFF = log2(WORDS).
  - idx = next log2(LINES) bits.
  - tag = the remaining upper bits.
- Reset (reset=0, async):
  - state=IDLE; all valid bits cleared; beat counter = 0.
  - req_ready=0 while reset=0, then 1 from the first clock after release.
  - resp_valid=0, mem_req_valid=0, resp_instr=0, mem_req_addr=0.
  - Tag and data arrays need not be reset.
- States: IDLE, MREQ, MDATA, RESP.
- req_ready = (state==IDLE) && !flush && !flush_pending.
- IDLE, request accepted (req_valid && req_ready): latch addr.
  - Hit (valid[idx] && tag match) → resp_valid=1 and resp_instr=data[idx][off] in the next cycle; stay IDLE. Back-to-back hits give one response per cycle.
  - Miss → MREQ.
- MREQ:
  - mem_req_valid=1, mem_req_addr = {tag, idx, 0…}.
  - addr and valid are held stable until mem_req_ready=1, then → MDATA.
- MDATA:
  - Each mem_resp_valid beat writes data[idx][cnt]; cnt increments.
  - On beat WORDS-1: set tag[idx] and valid[idx]=1, then → RESP.
  - Gaps between beats are allowed.
- RESP:
  - resp_valid=1, resp_instr = the requested word, read from the array just written.
  - → IDLE.
  - Miss latency = request handshake + WORDS beats + 1 cycle.
- mem_resp_valid outside MDATA is ignored.
- resp_valid is never asserted without a preceding accepted request; exactly one response per accepted request.
- Flush:
  - In IDLE: all valid bits clear on that edge; a concurrent req_valid is not accepted (req_ready=0).
  - During MREQ/MDATA/RESP: flush sets flush_pending. The refill completes and its response is still delivered. On entry to IDLE, all valid bits (including the new line) clear, flush_pending clears, and req_ready stays 0 for that cycle.
- Reset mid-refill: aborts immediately to the reset state. Beats still arriving afterwards are ignored.
- Conflict miss: the same idx with a different tag overwrites the line; no writeback (read-only cache).

Decomposition:
- Shared core_defines package holds:
  - state encoding (IDLE/MREQ/MDATA/RESP);
  - the instruction width constant (32);
  - the NOP encoding used by the F stage on bubbles.
- Derived widths (OFF_W, IDX_W, TAG_W) are computed locally via $clog2.
- One natural sub-module, icache_tagarray: valid bits, tags, hit compare, bulk invalidate. The data array and FSM stay in icache_dm.

Test Plan:
- Cold miss, LINES=16, WORDS=4: req 0x00000004 → mem_req_addr 0x00000000. Beats 0x00000000, 0x08000213, 0x000000B3, 0x04000113 → resp_instr 0x08000213, one cycle after the last beat.
- Hit after fill: req 0x0000000C → resp_instr 0x04000113 next cycle; no mem_req_valid. Four back-to-back hits over 0x0–0xC → four consecutive resp_valid cycles.
- Conflict: req 0x00000104 (idx 0, new tag) → refill from 0x00000100. A following req 0x00000004 misses again.
- Backpressure: mem_req_ready held 0 for 3 cycles → mem_req_valid and mem_req_addr stable. Beats with 2-cycle gaps → correct word returned.
- Flush: flush in IDLE, then req 0x00000004 → miss. Flush during MDATA → pending response still delivered (0x08000213), and the next req to the same line misses.
- Reset: assert reset=0 during MDATA beat 2 → all outputs 0 immediately. After release, stray mem_resp_valid is ignored; req 0x00000004 → fresh miss.
